letc_core_fetch_redirect_ctrl: RTL and testbench
================================================

LETC_CORE_FETCH_REDIRECT_CTRL -- requirements
Module: letc_core_fetch_redirect_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed (pc_t = 32 bits).
REQ-002 SHALL have ports, in this order (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- trap_req  in  1  trap/exception redirect request; held until acked.
- trap_target  in  32  trap target PC.
- fence_req  in  1  fence.i/sfence refetch request; held until acked.
- fence_target  in  32  refetch PC.
- br_req  in  1  branch mispredict redirect request; held until acked.
- br_target  in  32  corrected branch PC.
- req_ack  out  3  one-hot accept pulse: [2] trap, [1] fence, [0] branch.
- f1_stall  in  1  fetch1 stall from adhesive.
- pc_load_en  out  1  PC load strobe to fetch1.
- pc_load_val  out  32  PC load value to fetch1.
- f1_flush  out  1  flush fetch1.
- f2_flush  out  1  flush fetch2.
- busy  out  1  a redirect is latched or draining.
- redirect_count  out  32  count of issued redirects; present only with LETC_REDIRECT_COUNT_EN.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, DRAIN.
REQ-004 SHALL use fixed priority trap > fence > branch.
REQ-005 In IDLE or DRAIN, when any request is high, SHALL accept the highest-priority one.
- Acceptance pulses req_ack for that source combinationally in the same cycle.
- The target and the source ID are latched into target_ff/src_ff at the clock edge.
- The FSM moves to LOAD.
REQ-006 In LOAD, a request of strictly higher priority than src_ff SHALL preempt.
- req_ack pulses for the new source.
- target_ff/src_ff are overwritten.
- The FSM stays in LOAD.
- Equal- or lower-priority requests are not acked.
REQ-007 In LOAD with f1_stall=0:
- pc_load_en=1, f1_flush=1, f2_flush=1, pc_load_val=target_ff.
- Next state is DRAIN unless a preemption occurs (REQ-006 wins; the load is still issued this cycle and the preempting target loads in a later LOAD cycle).
REQ-008 In LOAD with f1_stall=1, SHALL hold pc_load_en=f1_flush=f2_flush=0 and remain in LOAD; f1_flush and f1_stall are never high together.
REQ-009 DRAIN SHALL last exactly one cycle.
- f2_flush=1, to kill the IMSS response in flight for the pre-redirect address.
- pc_load_en=0, f1_flush=0.
- Next state is IDLE, or LOAD if a request is accepted (REQ-005).
REQ-010 In IDLE: pc_load_en=f1_flush=f2_flush=0.
REQ-011 busy SHALL be 1 exactly when state != IDLE.
REQ-012 pc_load_val SHALL equal target_ff in every state; it is qualified only by pc_load_en.
REQ-013 Latency SHALL be: request accepted in cycle N with no stall at N+1 -> pc_load_en in cycle N+1 -> DRAIN in N+2 -> IDLE in N+3.
REQ-014 req_ack SHALL be one-hot or zero in every cycle.
REQ-015 The block SHALL NOT modify or check target alignment; targets pass through unchanged.

Reset
REQ-016 Asserting rst_n low SHALL immediately, without a clock edge, force:
- state=IDLE, target_ff=0, src_ff=branch, redirect_count=0.
- Therefore pc_load_en, f1_flush, f2_flush, busy and pc_load_val are all 0.
REQ-017 Reset asserted mid-LOAD or mid-DRAIN SHALL discard the latched redirect; no pc_load_en follows deassertion unless a request is present.
REQ-018 req_ack SHALL be 0 while rst_n is low.

Configuration
REQ-019 With LETC_REDIRECT_COUNT_EN defined:
- redirect_count exists and increments by 1 on each cycle with pc_load_en=1.
- It wraps modulo 2^32 (0xFFFFFFFF -> 0).
REQ-020 Without LETC_REDIRECT_COUNT_EN, the redirect_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Single branch: br_req=1, br_target=0x80000100 at cycle 0, f1_stall=0 -> req_ack=3'b001 at cycle 0; at cycle 1 pc_load_en=1, pc_load_val=0x80000100, f1/f2_flush=1; at cycle 2 f2_flush only; at cycle 3 busy=0.
- Simultaneous requests: trap_req (0x00000040), fence_req, br_req all at cycle 0 -> req_ack=3'b100; pc_load_val=0x00000040; fence acked at cycle 2 (DRAIN), load at cycle 3.
- Stall hold: branch accepted, f1_stall=1 for cycles 1-3 -> no pc_load_en or flush in cycles 1-3; load at cycle 4; f1_flush never coincides with f1_stall.
- Preemption: branch 0x100 accepted at 0, f1_stall=1, trap 0x200 at 1 -> req_ack=3'b100 at 1; single load of 0x200 once the stall drops; no load of 0x100.
- Async reset mid-LOAD: rst_n low between edges -> outputs 0 immediately; after release with no requests, no pc_load_en.
- Counter (macro on): preload near wrap via 2^32 redirects, or force the counter to 0xFFFFFFFF -> one redirect -> 0.

Source files
------------

// File: rtl/letc_core_fetch_redirect_ctrl.sv
// rtl/letc_core_fetch_redirect_ctrl.sv - fetch redirect arbiter/sequencer (optional LETC_REDIRECT_COUNT_EN adds redirect_count)
module letc_core_fetch_redirect_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic [31:0] trap_target,
    input  logic        fence_req,
    input  logic [31:0] fence_target,
    input  logic        br_req,
    input  logic [31:0] br_target,
    output logic [2:0]  req_ack,
    input  logic        f1_stall,
    output logic        pc_load_en,
    output logic [31:0] pc_load_val,
    output logic        f1_flush,
    output logic        f2_flush,
    output logic        busy
`ifdef LETC_REDIRECT_COUNT_EN
    ,
    output logic [31:0] redirect_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Source IDs double as priority levels: a larger value wins.
    typedef enum logic [1:0] {
        SRC_BR    = 2'd0,
        SRC_FENCE = 2'd1,
        SRC_TRAP  = 2'd2
    } src_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] target_q;
    logic [31:0] target_d;
    src_t        src_q;
    src_t        src_d;

    logic        win_valid;
    src_t        win_src;
    logic [31:0] win_target;
    logic        accept;

    // Fixed-priority pick among the pending requests: trap, then fence, then branch.
    always_comb begin
        win_valid  = 1'b0;
        win_src    = SRC_BR;
        win_target = br_target;
        if (trap_req) begin
            win_valid  = 1'b1;
            win_src    = SRC_TRAP;
            win_target = trap_target;
        end else if (fence_req) begin
            win_valid  = 1'b1;
            win_src    = SRC_FENCE;
            win_target = fence_target;
        end else if (br_req) begin
            win_valid  = 1'b1;
            win_src    = SRC_BR;
            win_target = br_target;
        end
    end

    // Next-state, acceptance and fetch-control outputs.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        src_d      = src_q;
        accept     = 1'b0;
        req_ack    = 3'b000;
        pc_load_en = 1'b0;
        f1_flush   = 1'b0;
        f2_flush   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Only a strictly more urgent source may replace the latched one.
                if (win_valid && (win_src > src_q)) begin
                    accept = 1'b1;
                end
                if (!f1_stall) begin
                    // The currently latched target still loads this cycle even if
                    // it is being preempted; the new target loads on a later LOAD.
                    pc_load_en = 1'b1;
                    f1_flush   = 1'b1;
                    f2_flush   = 1'b1;
                    state_d    = accept ? ST_LOAD : ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                // Kill the fetch2 response still in flight for the old address.
                f2_flush = 1'b1;
                if (win_valid) begin
                    accept  = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            target_d = win_target;
            src_d    = win_src;
            case (win_src)
                SRC_TRAP:  req_ack = 3'b100;
                SRC_FENCE: req_ack = 3'b010;
                default:   req_ack = 3'b001;
            endcase
        end

        // No handshake may complete while the block is held in reset.
        if (!rst_n) begin
            req_ack = 3'b000;
        end
    end

    // State and latched redirect registers; reset discards any redirect in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            target_q <= 32'h0000_0000;
            src_q    <= SRC_BR;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            src_q    <= src_d;
        end
    end

    assign pc_load_val = target_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef LETC_REDIRECT_COUNT_EN
    logic [31:0] count_q;

    // Count every issued PC load; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'h0000_0000;
        end else if (pc_load_en) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign redirect_count = count_q;
`endif

endmodule

// File: tb/tb_letc_core_fetch_redirect_ctrl.sv
// tb/tb_letc_core_fetch_redirect_ctrl.sv - self-checking bench for letc_core_fetch_redirect_ctrl
module tb_letc_core_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_target = 32'h0;
    logic        fence_req = 1'b0;
    logic [31:0] fence_target = 32'h0;
    logic        br_req = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [2:0]  req_ack;
    logic        f1_stall = 1'b0;
    logic        pc_load_en;
    logic [31:0] pc_load_val;
    logic        f1_flush;
    logic        f2_flush;
    logic        busy;
`ifdef LETC_REDIRECT_COUNT_EN
    logic [31:0] redirect_count;
`endif

    int passed = 0;
    int total  = 0;

    letc_core_fetch_redirect_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trap_req     (trap_req),
        .trap_target  (trap_target),
        .fence_req    (fence_req),
        .fence_target (fence_target),
        .br_req       (br_req),
        .br_target    (br_target),
        .req_ack      (req_ack),
        .f1_stall     (f1_stall),
        .pc_load_en   (pc_load_en),
        .pc_load_val  (pc_load_val),
        .f1_flush     (f1_flush),
        .f2_flush     (f2_flush),
        .busy         (busy)
`ifdef LETC_REDIRECT_COUNT_EN
        ,
        .redirect_count (redirect_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a pending redirect (if any) with its priority, a one-cycle
    // post-load flush marker, and the last target ever accepted.
    bit          m_pend;
    int          m_prio;
    bit          m_drain;
    logic [31:0] m_last;
    logic [31:0] m_cnt;

    logic [2:0]  e_ack;
    bit          e_load;
    bit          e_f2;
    bit          e_busy;
    logic [31:0] e_val;
    int          e_nprio;
    logic [31:0] e_ntgt;

    task automatic model_eval();
        int          best;
        logic [31:0] btgt;
        best = -1;
        btgt = 32'h0;
        if (trap_req) begin
            best = 2; btgt = trap_target;
        end else if (fence_req) begin
            best = 1; btgt = fence_target;
        end else if (br_req) begin
            best = 0; btgt = br_target;
        end
        e_ack   = 3'b000;
        e_nprio = best;
        e_ntgt  = btgt;
        if (!rst_n) begin
            e_load = 0; e_f2 = 0; e_busy = 0; e_val = 32'h0;
        end else begin
            if (best >= 0 && (!m_pend || best > m_prio)) e_ack = 3'(1 << best);
            e_load = m_pend && !f1_stall;
            e_f2   = e_load || m_drain;
            e_busy = m_pend || m_drain;
            e_val  = m_last;
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        model_eval();
        chk("req_ack",     32'(req_ack),     32'(e_ack));
        chk("pc_load_en",  32'(pc_load_en),  32'(e_load));
        chk("f1_flush",    32'(f1_flush),    32'(e_load));
        chk("f2_flush",    32'(f2_flush),    32'(e_f2));
        chk("busy",        32'(busy),        32'(e_busy));
        chk("pc_load_val", pc_load_val,      e_val);
        chk("ack_onehot0", 32'($onehot0(req_ack)), 32'd1);
        chk("f1flush_vs_stall", 32'(f1_flush && f1_stall), 32'd0);
`ifdef LETC_REDIRECT_COUNT_EN
        chk("redirect_count", redirect_count, m_cnt);
`endif
    end

    // Advance the model on each clock using the expectations formed for that cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_prio = 0; m_drain = 0; m_last = 32'h0; m_cnt = 32'h0;
        end else begin
            if (e_load) m_cnt = m_cnt + 32'd1;
            if (e_ack != 3'b000) begin
                m_pend = 1; m_prio = e_nprio; m_last = e_ntgt; m_drain = 0;
            end else if (e_load) begin
                m_pend = 0; m_drain = 1;
            end else if (m_drain) begin
                m_drain = 0;
            end
        end
    end

    task automatic cyc(input logic t, input logic f, input logic b, input logic s);
        @(posedge clk);
        #1;
        trap_req = t; fence_req = f; br_req = b; f1_stall = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_val", pc_load_val, 32'h0);
        #1 rst_n = 1'b1;
        idle(2);

        // Single branch redirect.
        br_target = 32'h8000_0100;
        cyc(0, 0, 1, 0);
        chk("s1_ack", 32'(req_ack), 32'b001);
        cyc(0, 0, 0, 0);
        chk("s1_load", 32'(pc_load_en), 32'd1);
        chk("s1_val", pc_load_val, 32'h8000_0100);
        chk("s1_f1", 32'(f1_flush), 32'd1);
        chk("s1_f2", 32'(f2_flush), 32'd1);
        cyc(0, 0, 0, 0);
        chk("s1_drain_f2", 32'(f2_flush), 32'd1);
        chk("s1_drain_load", 32'(pc_load_en), 32'd0);
        cyc(0, 0, 0, 0);
        chk("s1_idle_busy", 32'(busy), 32'd0);
        idle(1);

        // Simultaneous requests resolve in priority order.
        trap_target = 32'h0000_0040; fence_target = 32'h0000_1000; br_target = 32'h0000_2000;
        cyc(1, 1, 1, 0);
        chk("s2_ack0", 32'(req_ack), 32'b100);
        cyc(0, 1, 1, 0);
        chk("s2_ack1", 32'(req_ack), 32'b000);
        chk("s2_val1", pc_load_val, 32'h0000_0040);
        chk("s2_load1", 32'(pc_load_en), 32'd1);
        cyc(0, 1, 1, 0);
        chk("s2_ack2", 32'(req_ack), 32'b010);
        chk("s2_f2_2", 32'(f2_flush), 32'd1);
        cyc(0, 0, 1, 0);
        chk("s2_load3", 32'(pc_load_en), 32'd1);
        chk("s2_val3", pc_load_val, 32'h0000_1000);
        cyc(0, 0, 1, 0);
        chk("s2_ack4", 32'(req_ack), 32'b001);
        cyc(0, 0, 0, 0);
        chk("s2_val5", pc_load_val, 32'h0000_2000);
        idle(3);

        // Stall holds the load.
        br_target = 32'h0000_0300;
        cyc(0, 0, 1, 0);
        chk("s3_ack", 32'(req_ack), 32'b001);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 1);
            chk("s3_noload", 32'(pc_load_en), 32'd0);
            chk("s3_nof2", 32'(f2_flush), 32'd0);
            chk("s3_busy", 32'(busy), 32'd1);
        end
        cyc(0, 0, 0, 0);
        chk("s3_load4", 32'(pc_load_en), 32'd1);
        chk("s3_val4", pc_load_val, 32'h0000_0300);
        idle(3);

        // Preemption during a stall: only the trap target loads.
        br_target = 32'h0000_0100; trap_target = 32'h0000_0200;
        cyc(0, 0, 1, 1);
        chk("s4_ack0", 32'(req_ack), 32'b001);
        cyc(1, 0, 0, 1);
        chk("s4_ack1", 32'(req_ack), 32'b100);
        chk("s4_noload1", 32'(pc_load_en), 32'd0);
        cyc(0, 0, 0, 0);
        chk("s4_load2", 32'(pc_load_en), 32'd1);
        chk("s4_val2", pc_load_val, 32'h0000_0200);
        cyc(0, 0, 0, 0);
        chk("s4_noload3", 32'(pc_load_en), 32'd0);
        idle(2);

        // Preemption in an unstalled LOAD: old target loads, then the new one.
        br_target = 32'h0000_0700; trap_target = 32'h0000_0800;
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("s7_ack1", 32'(req_ack), 32'b100);
        chk("s7_val1", pc_load_val, 32'h0000_0700);
        chk("s7_load1", 32'(pc_load_en), 32'd1);
        cyc(0, 0, 0, 0);
        chk("s7_load2", 32'(pc_load_en), 32'd1);
        chk("s7_val2", pc_load_val, 32'h0000_0800);
        cyc(0, 0, 0, 0);
        chk("s7_drain", 32'(f2_flush), 32'd1);
        idle(2);

        // Asynchronous reset in the middle of LOAD.
        br_target = 32'h0000_0500;
        cyc(0, 0, 1, 0);
        @(posedge clk);
        #1 br_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("s5_load", 32'(pc_load_en), 32'd0);
        chk("s5_f1", 32'(f1_flush), 32'd0);
        chk("s5_f2", 32'(f2_flush), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_val", pc_load_val, 32'h0);
        br_req = 1'b1;
        #1;
        chk("s5_ack_in_reset", 32'(req_ack), 32'b000);
        br_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("s5_noload_after", 32'(pc_load_en), 32'd0);
        end

`ifdef LETC_REDIRECT_COUNT_EN
        // Counter wrap.
        @(posedge clk);
        #1;
        force dut.count_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        br_target = 32'h0000_0900;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("s6_cnt_before", redirect_count, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0);
        chk("s6_cnt_wrap", redirect_count, 32'h0);
        idle(2);
`endif

        idle(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
